// File: rtl/inst_gen.sv
// inst_gen: instruction sequencer for one systolic-array tile.
//
// Walks weight load (WLOAD), kernel load (KLOAD), activation load (XLOAD),
// execute (EXEC) and output drain (DRAIN), then pulses done. The 34-bit
// instruction word is registered, and it is built from the next-state
// values, so the word seen in a cycle always belongs to the state of that
// same cycle.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-low
//   start        run-one-tile request, honoured only in IDLE
//   x_base       activation SRAM start address (captured at start)
//   w_base       weight SRAM start address (captured at start)
//   len          activation vector count T (captured at start)
//   acc_en       accumulate request (captured at start)
//   ofifo_valid  core output FIFO holds data
//   inst         registered instruction word
//   busy         tile in progress (first cycle after start through DONE)
//   done         one-cycle completion pulse
//
// Build option
//   INST_GEN_ACC_EN  when defined, inst[33] carries the captured acc_en on
//                    DRAIN read cycles; otherwise inst[33] is tied to 0.
//
// state | meaning
// IDLE  | idle word, waiting for start
// WLOAD | read row weight vectors from pmem into the input FIFO
// KLOAD | col cycles shifting weights into the PE array
// XLOAD | read len activation vectors from xmem into L0
// EXEC  | len cycles streaming L0 into the array
// DRAIN | read len results out of the output FIFO
// DONE  | one-cycle completion pulse

module inst_gen #(
  parameter int row = 8,
  parameter int col = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] x_base,
  input  logic [10:0] w_base,
  input  logic [10:0] len,
  input  logic        acc_en,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done
);

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  localparam int B_ACC      = 33;
  localparam int B_CEN_PMEM = 32;
  localparam int B_CEN_XMEM = 19;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXECUTE  = 1;
  localparam int B_LOAD     = 0;

  localparam logic [11:0] WLOAD_LEN = 12'(row + 1);
  localparam logic [11:0] KLOAD_LEN = 12'(col);

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_KLOAD, S_XLOAD, S_EXEC, S_DRAIN, S_DONE
  } state_e;

  state_e      state_q, state_d;
  // rem_q: cycles (or, in DRAIN, reads) left in the current phase, counting
  // down to a terminal value of 1.
  logic [11:0] rem_q, rem_d;
  logic [10:0] addr_q, addr_d;
  logic [33:0] inst_q, inst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [10:0] x_base_q, len_q;
  logic        acc_q;

  logic [11:0] len_ext;
  assign len_ext = {1'b0, len_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_base_q <= '0;
      len_q    <= '0;
      acc_q    <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      x_base_q <= x_base;
      len_q    <= len;
      acc_q    <= acc_en;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
      inst_q  <= IDLE_WORD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state, phase counter and SRAM address.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WLOAD;
          rem_d   = WLOAD_LEN;
          addr_d  = w_base;
        end
      end
      S_WLOAD: begin
        if (rem_q == 12'd1) begin
          state_d = S_KLOAD;
          rem_d   = KLOAD_LEN;
        end else begin
          rem_d  = rem_q - 12'd1;
          addr_d = addr_q + 11'd1;
        end
      end
      S_KLOAD: begin
        if (rem_q == 12'd1) begin
          if (len_q == 11'd0) begin
            state_d = S_DONE;
            rem_d   = '0;
          end else begin
            state_d = S_XLOAD;
            rem_d   = len_ext + 12'd1;
            addr_d  = x_base_q;
          end
        end else begin
          rem_d = rem_q - 12'd1;
        end
      end
      S_XLOAD: begin
        if (rem_q == 12'd1) begin
          state_d = S_EXEC;
          rem_d   = len_ext;
        end else begin
          rem_d  = rem_q - 12'd1;
          addr_d = addr_q + 11'd1;
        end
      end
      S_EXEC: begin
        if (rem_q == 12'd1) begin
          state_d = S_DRAIN;
          rem_d   = len_ext;
        end else begin
          rem_d = rem_q - 12'd1;
        end
      end
      S_DRAIN: begin
        // Only cycles that actually issued ofifo_rd count as reads.
        if (inst_q[B_OFIFO_RD]) begin
          if (rem_q == 12'd1) begin
            state_d = S_DONE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - 12'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rem_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = '0;
      end
    endcase
  end

  // Instruction word for the cycle that follows this edge. The last cycle of
  // each load phase (rem == 1) issues no SRAM read, and the first cycle
  // (rem == full length) has no data back yet to write into the FIFO.
  always_comb begin
    inst_d = IDLE_WORD;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    unique case (state_d)
      S_WLOAD: begin
        if (rem_d != 12'd1) begin
          inst_d[B_CEN_PMEM] = 1'b0;
          inst_d[30:20]      = addr_d;
        end
        if (rem_d != WLOAD_LEN) inst_d[B_IFIFO_WR] = 1'b1;
      end
      S_KLOAD: begin
        inst_d[B_IFIFO_RD] = 1'b1;
        inst_d[B_LOAD]     = 1'b1;
      end
      S_XLOAD: begin
        if (rem_d != 12'd1) begin
          inst_d[B_CEN_XMEM] = 1'b0;
          inst_d[17:7]       = addr_d;
        end
        if (rem_d != len_ext + 12'd1) inst_d[B_L0_WR] = 1'b1;
      end
      S_EXEC: begin
        inst_d[B_L0_RD]   = 1'b1;
        inst_d[B_EXECUTE] = 1'b1;
      end
      S_DRAIN: begin
        inst_d[B_OFIFO_RD] = ofifo_valid;
`ifdef INST_GEN_ACC_EN
        inst_d[B_ACC]      = acc_q & ofifo_valid;
`endif
      end
      default: begin
        inst_d = IDLE_WORD;
      end
    endcase
  end

`ifndef INST_GEN_ACC_EN
  logic unused_acc;
  assign unused_acc = acc_q;
`endif

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_inst_gen.sv
`timescale 1ns/1ps
module tb_inst_gen;
  localparam int ROW = 8;
  localparam int COL = 8;
  localparam logic [33:0] IDLE = 34'h1_800C_0000;

  logic        clk, reset, start, acc_en, ofifo_valid;
  logic [10:0] x_base, w_base, len;
  logic [33:0] inst;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [33:0] inst;
    logic        busy;
    logic        done;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [10:0] w;
    logic [10:0] x;
    logic [10:0] l;
    logic        a;
    logic [7:0]  pat;   // ofifo_valid per DRAIN decision, bit 0 first
    int          plen;  // bits of pat used; 1 afterwards
    bit          poke;  // pulse start while in WLOAD
    int          cyc;   // words from start acceptance through DONE
  } vec_t;
  vec_t vecs[6];

  inst_gen #(.row(ROW), .col(COL)) dut (
    .clk(clk), .reset(reset), .start(start), .x_base(x_base),
    .w_base(w_base), .len(len), .acc_en(acc_en), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(logic [33:0] w, logic b, logic d);
    exp_t e;
    e.inst = w; e.busy = b; e.done = d;
    q.push_back(e);
  endfunction

  task automatic chk_word(input string nm, input int tag, input exp_t e);
    total++;
    if (inst !== e.inst || busy !== e.busy || done !== e.done) begin
      bad++;
      $display("FAIL %s[%0d] got inst=%h busy=%b done=%b want inst=%h busy=%b done=%b",
               nm, tag, inst, busy, done, e.inst, e.busy, e.done);
    end
  endtask

  task automatic chk_val(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic run_tile(input int id, input vec_t v);
    logic [33:0] w;
    logic [10:0] a;
    logic        rd;
    exp_t        e;
    int ds, j, reads, done_at, i;
    q.delete();
    for (int k = 0; k <= ROW; k++) begin
      w = IDLE;
      if (k < ROW) begin
        w[32] = 1'b0;
        a = v.w + 11'(k);
        w[30:20] = a;
      end
      if (k >= 1) w[5] = 1'b1;
      push(w, 1'b1, 1'b0);
    end
    for (int k = 0; k < COL; k++) begin
      w = IDLE; w[4] = 1'b1; w[0] = 1'b1;
      push(w, 1'b1, 1'b0);
    end
    ds = ROW + 1 + COL + 2 * int'(v.l) + 1;
    if (v.l != 11'd0) begin
      for (int t = 0; t <= int'(v.l); t++) begin
        w = IDLE;
        if (t < int'(v.l)) begin
          w[19] = 1'b0;
          a = v.x + 11'(t);
          w[17:7] = a;
        end
        if (t >= 1) w[2] = 1'b1;
        push(w, 1'b1, 1'b0);
      end
      for (int t = 0; t < int'(v.l); t++) begin
        w = IDLE; w[3] = 1'b1; w[1] = 1'b1;
        push(w, 1'b1, 1'b0);
      end
      reads = 0; j = 0;
      while (reads < int'(v.l)) begin
        rd = (j < v.plen) ? v.pat[j] : 1'b1;
        w = IDLE; w[6] = rd;
`ifdef INST_GEN_ACC_EN
        w[33] = rd & v.a;
`endif
        push(w, 1'b1, 1'b0);
        reads += int'(rd);
        j++;
      end
    end
    push(IDLE, 1'b1, 1'b1);
    push(IDLE, 1'b0, 1'b0);

    w_base = v.w; x_base = v.x; len = v.l; acc_en = v.a;
    ofifo_valid = 1'b1; start = 1'b1;
    tick();
    // Scramble the inputs: the tile must run from the captured copies.
    start = 1'b0; w_base = 11'h555; x_base = 11'h2AA; len = 11'd7; acc_en = ~v.a;
    i = 0; done_at = -1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk_word($sformatf("tile%0d.word", id), i, e);
      if (done === 1'b1 && done_at < 0) done_at = i;
      j = i + 1 - ds;
      ofifo_valid = (v.l != 11'd0 && j >= 0 && j < v.plen) ? v.pat[j] : 1'b1;
      start = v.poke && (i == 1 || i == 2);
      tick();
      i++;
    end
    start = 1'b0;
    chk_val($sformatf("tile%0d.cycles_to_done", id), done_at + 1, v.cyc);
  endtask

  exp_t idle_e;

  initial begin
    reset = 1'b0; start = 1'b0; acc_en = 1'b0; ofifo_valid = 1'b1;
    x_base = '0; w_base = '0; len = '0;
    idle_e.inst = IDLE; idle_e.busy = 1'b0; idle_e.done = 1'b0;

    vecs[0] = '{11'h010, 11'h100, 11'd4, 1'b0, 8'hFF, 0, 1'b0, 31};
    vecs[1] = '{11'h020, 11'h7FE, 11'd4, 1'b1, 8'hFF, 0, 1'b0, 31};
    vecs[2] = '{11'h7FC, 11'h030, 11'd4, 1'b1, 8'h39, 6, 1'b0, 33};
    vecs[3] = '{11'h7F9, 11'h000, 11'd0, 1'b1, 8'hFF, 0, 1'b1, 18};
    vecs[4] = '{11'h100, 11'h200, 11'd1, 1'b1, 8'h02, 2, 1'b0, 23};
    vecs[5] = '{11'h3FF, 11'h0AB, 11'd3, 1'b0, 8'h16, 5, 1'b0, 30};

    tick();
    tick();
    chk_word("reset_state", 0, idle_e);
    reset = 1'b1;
    tick();
    chk_word("idle_after_release", 0, idle_e);

    for (int n = 0; n < 6; n++) run_tile(n, vecs[n]);

    // Abandon a tile in EXEC with an asynchronous reset.
    w_base = 11'h000; x_base = 11'h040; len = 11'd4; acc_en = 1'b1;
    ofifo_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (ROW + 1 + COL + 5 + 1) tick();
    chk_val("in_exec_before_reset", int'(inst[1]), 1);
    #2 reset = 1'b0;
    #1;
    chk_word("reset_mid_exec", 0, idle_e);
    tick();
    chk_word("reset_held", 0, idle_e);
    reset = 1'b1;
    tick();
    chk_word("idle_after_abort", 0, idle_e);
    run_tile(6, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
